// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the sequential ALU with 7-segment display.
// Holds the FSM state and opcode encodings and the active-low hex segment table.
package alu_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_A   = 2'd0,
        WAIT_B   = 2'd1,
        WAIT_OP  = 2'd2,
        SHOW_RES = 2'd3
    } state_e;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_OR   = 3'd3,
        OP_XOR  = 3'd4,
        OP_SHL  = 3'd5,
        OP_SHR  = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/seg7_scan.sv
// Time-multiplexed 8-digit hex display driver: each digit stays lit for
// REFRESH_CNT cycles; digits beyond WIDTH/4 are blanked.
module seg7_scan
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int REFRESH_CNT = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] value_i,
    output logic [6:0]       segments_o,
    output logic [7:0]       anodes_o
);

    localparam int CW   = (REFRESH_CNT > 2) ? $clog2(REFRESH_CNT) : 1;
    localparam int NDIG = WIDTH / 4;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [31:0]   val32;
    logic [3:0]    nib;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q <= '0;
            idx_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
        end
    end

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        idx_d = idx_q;
        if (cnt_q == CW'(REFRESH_CNT - 1)) begin
            cnt_d = '0;
            idx_d = idx_q + 3'd1;
        end
    end

    always_comb begin
        val32 = '0;
        val32[WIDTH-1:0] = value_i;
        nib = val32[{idx_q, 2'b00} +: 4];
        if (int'(idx_q) < NDIG) begin
            anodes_o   = ~(8'b1 << idx_q);
            segments_o = SEG_LUT[nib];
        end else begin
            anodes_o   = 8'hFF;
            segments_o = SEG_BLANK;
        end
    end

endmodule

// File: rtl/alu_seq_display.sv
// Operand/opcode entry FSM with registered ALU result shown on a scanned display.
// Define ALU_SEQ_FLAGS_EN to build the {N,Z,C,V} flag register; otherwise flags read 0.
module alu_seq_display
    import alu_seq_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int REFRESH_CNT = 50000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data_in,
    input  logic             enter,
    output logic [1:0]       state_o,
    output logic [3:0]       flags,
    output logic [6:0]       segments,
    output logic [7:0]       anodes
);

    localparam int M = WIDTH - 1;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] reg_a_q, reg_b_q, reg_res_q;
    logic [2:0]       reg_op_q;
    op_e              op_sel;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] disp_val;

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= WAIT_A;
        else        state_q <= state_d;
    end

    // Next-state logic: every cycle with enter high advances one state
    always_comb begin
        state_d = state_q;
        if (enter) begin
            case (state_q)
                WAIT_A:   state_d = WAIT_B;
                WAIT_B:   state_d = WAIT_OP;
                WAIT_OP:  state_d = SHOW_RES;
                default:  state_d = WAIT_A;
            endcase
        end
    end

    // Output logic
    always_comb begin
        state_o  = state_q;
        disp_val = (state_q == SHOW_RES) ? reg_res_q : data_in;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            reg_a_q   <= '0;
            reg_b_q   <= '0;
            reg_op_q  <= '0;
            reg_res_q <= '0;
        end else if (enter) begin
            case (state_q)
                WAIT_A:  reg_a_q <= data_in;
                WAIT_B:  reg_b_q <= data_in;
                WAIT_OP: begin
                    reg_op_q  <= data_in[2:0];
                    reg_res_q <= alu_res;
                end
                default: ;
            endcase
        end
    end

    // The result only loads in WAIT_OP, where the live switch opcode is used.
    assign op_sel = op_e'((state_q == WAIT_OP) ? data_in[2:0] : reg_op_q);

    always_comb begin
        alu_res = '0;
        case (op_sel)
            OP_ADD:  alu_res = reg_a_q + reg_b_q;
            OP_SUB:  alu_res = reg_a_q - reg_b_q;
            OP_AND:  alu_res = reg_a_q & reg_b_q;
            OP_OR:   alu_res = reg_a_q | reg_b_q;
            OP_XOR:  alu_res = reg_a_q ^ reg_b_q;
            OP_SHL:  alu_res = {reg_a_q[M-1:0], 1'b0};
            OP_SHR:  alu_res = {1'b0, reg_a_q[M:1]};
            default: alu_res = reg_a_q;
        endcase
    end

`ifdef ALU_SEQ_FLAGS_EN
    logic [WIDTH:0] sum_x, dif_x;
    logic           c_flag, v_flag;
    logic [3:0]     alu_flags, flags_q;

    assign sum_x = {1'b0, reg_a_q} + {1'b0, reg_b_q};
    assign dif_x = {1'b0, reg_a_q} - {1'b0, reg_b_q};

    always_comb begin
        c_flag = 1'b0;
        v_flag = 1'b0;
        case (op_sel)
            OP_ADD: begin
                c_flag = sum_x[WIDTH];
                v_flag = (reg_a_q[M] == reg_b_q[M]) && (alu_res[M] != reg_a_q[M]);
            end
            OP_SUB: begin
                c_flag = ~dif_x[WIDTH];
                v_flag = (reg_a_q[M] != reg_b_q[M]) && (alu_res[M] != reg_a_q[M]);
            end
            OP_SHL:  c_flag = reg_a_q[M];
            OP_SHR:  c_flag = reg_a_q[0];
            default: ;
        endcase
        alu_flags = {alu_res[M], (alu_res == '0), c_flag, v_flag};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         flags_q <= '0;
        else if (enter && state_q == WAIT_OP) flags_q <= alu_flags;
    end

    assign flags = flags_q;
`else
    assign flags = 4'b0000;
`endif

    seg7_scan #(
        .WIDTH       (WIDTH),
        .REFRESH_CNT (REFRESH_CNT)
    ) u_scan (
        .clk        (clk),
        .reset      (reset),
        .value_i    (disp_val),
        .segments_o (segments),
        .anodes_o   (anodes)
    );

endmodule

// File: tb/tb_alu_seq_display.sv
// Directed bench for alu_seq_display (WIDTH=8, REFRESH_CNT=4); expected flags
// follow ALU_SEQ_FLAGS_EN so the same bench serves both builds.
module tb_alu_seq_display;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = 8'h35;
    logic       enter = 1'b0;
    logic [1:0] state_o;
    logic [3:0] flags;
    logic [6:0] segments;
    logic [7:0] anodes;

    int checks = 0;
    int failures = 0;

    alu_seq_display #(.WIDTH(8), .REFRESH_CNT(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .data_in  (data_in),
        .enter    (enter),
        .state_o  (state_o),
        .flags    (flags),
        .segments (segments),
        .anodes   (anodes)
    );

    always #5 clk = ~clk;

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] hi;
        case (n)
            4'h0: hi = 7'h3F; 4'h1: hi = 7'h06; 4'h2: hi = 7'h5B; 4'h3: hi = 7'h4F;
            4'h4: hi = 7'h66; 4'h5: hi = 7'h6D; 4'h6: hi = 7'h7D; 4'h7: hi = 7'h07;
            4'h8: hi = 7'h7F; 4'h9: hi = 7'h6F; 4'hA: hi = 7'h77; 4'hB: hi = 7'h7C;
            4'hC: hi = 7'h39; 4'hD: hi = 7'h5E; 4'hE: hi = 7'h79; default: hi = 7'h71;
        endcase
        return ~hi;
    endfunction

    function automatic logic [3:0] fexp(input logic [3:0] f);
`ifdef ALU_SEQ_FLAGS_EN
        return f;
`else
        return 4'b0000;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic press(input logic [7:0] v);
        @(negedge clk);
        data_in = v;
        enter   = 1'b1;
        @(negedge clk);
        enter   = 1'b0;
    endtask

    task automatic wait_anode(input string tag, input logic [7:0] an);
        int n = 0;
        while (anodes !== an && n < 40) begin
            @(negedge clk);
            n++;
        end
        check(tag, anodes, an);
    endtask

    // Enter A, B, op; check latency-1 result/flags, then return to WAIT_A.
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b,
                          input logic [2:0] op, input logic [7:0] res, input logic [3:0] f);
        press(a);
        press(b);
        press({5'b0, op});
        check({tag, "_state"}, state_o, 2'd3);
        check({tag, "_flags"}, flags, fexp(f));
        wait_anode({tag, "_an0"}, 8'hFE);
        check({tag, "_dig0"}, segments, seg_of(res[3:0]));
        wait_anode({tag, "_an1"}, 8'hFD);
        check({tag, "_dig1"}, segments, seg_of(res[7:4]));
        press(8'h00);
        check({tag, "_back"}, state_o, 2'd0);
        check({tag, "_keep"}, flags, fexp(f));
    endtask

    initial begin
        logic [1:0] hold_exp [5];
        hold_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

        // Asynchronous reset, no clock edge needed
        #3 reset = 1'b0;
        #1;
        check("rst_state", state_o, 2'd0);
        check("rst_flags", flags, 4'h0);
        check("rst_anodes", anodes, 8'hFE);
        check("rst_segs", segments, seg_of(4'h5));
        @(negedge clk);
        reset = 1'b1;

        run_op("add_ovf", 8'h7F, 8'h01, 3'd0, 8'h80, 4'b1001);
        run_op("sub_zero", 8'h05, 8'h05, 3'd1, 8'h00, 4'b0110);
        run_op("shl", 8'h81, 8'h00, 3'd5, 8'h02, 4'b0010);
        run_op("sub_ovf", 8'h80, 8'h01, 3'd1, 8'h7F, 4'b0011);
        run_op("xor", 8'hF0, 8'h3C, 3'd4, 8'hCC, 4'b1000);
        run_op("shr", 8'h03, 8'h00, 3'd6, 8'h01, 4'b0010);

        // Pass A3, show 3 then A, then blank digit 2
        press(8'hA3);
        press(8'h00);
        press(8'h07);
        check("pass_flags", flags, fexp(4'b1000));
        wait_anode("pass_an0", 8'hFE);
        check("pass_dig0", segments, seg_of(4'h3));
        wait_anode("pass_an1", 8'hFD);
        check("pass_dig1", segments, seg_of(4'hA));
        repeat (4) @(negedge clk);
        check("blank_an", anodes, 8'hFF);
        check("blank_seg", segments, 7'h7F);
        press(8'h00);

        // WAIT_A displays live switches
        data_in = 8'h4C;
        wait_anode("live_an0", 8'hFE);
        check("live_dig0", segments, seg_of(4'hC));
        wait_anode("live_an1", 8'hFD);
        check("live_dig1", segments, seg_of(4'h4));

        // Enter held for five cycles: 0+0 ADD passes through WAIT_OP
        @(negedge clk);
        data_in = 8'h00;
        enter   = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("hold_%0d", i), state_o, hold_exp[i]);
        end
        enter = 1'b0;
        check("hold_flags", flags, fexp(4'b0100));

        // Reset mid-cycle while in WAIT_OP
        press(8'h55);
        check("pre_rst_state", state_o, 2'd2);
        data_in = 8'h09;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_state", state_o, 2'd0);
        check("mid_rst_flags", flags, 4'h0);
        check("mid_rst_anodes", anodes, 8'hFE);
        check("mid_rst_segs", segments, seg_of(4'h9));
        @(negedge clk);
        reset = 1'b1;

        run_op("after_rst", 8'h12, 8'h34, 3'd3, 8'h36, 4'b0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq_display.md
ALU_SEQ_DISPLAY -- requirements
Module: alu_seq_display

Interface
REQ-001 Parameter WIDTH, default 8, operand/result width; SHALL be a multiple of 4 in 4..32.
REQ-002 Parameter REFRESH_CNT, default 50000, clock cycles each display digit stays lit; SHALL be >= 2.
REQ-003 Port clk  input  1  single system clock, all state rising-edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port data_in  input  WIDTH  switch value: operand A, operand B or opcode (data_in[2:0]).
REQ-006 Port enter  input  1  already-debounced single-cycle advance pulse.
REQ-007 Port state_o  output  2  current FSM state encoding.
REQ-008 Port flags  output  4  {N,Z,C,V} of the last result.
REQ-009 Port segments  output  7  active-low segments {g..a} of the lit digit.
REQ-010 Port anodes  output  8  active-low one-hot digit enables.

Function
REQ-011 FSM states, encoded 0..3: WAIT_A, WAIT_B, WAIT_OP, SHOW_RES; state_o SHALL equal the encoding.
REQ-012 enter high SHALL advance WAIT_A->WAIT_B->WAIT_OP->SHOW_RES->WAIT_A, one step per pulse; enter low holds state.
REQ-013 On enter in WAIT_A, reg_A <= data_in; in WAIT_B, reg_B <= data_in; in WAIT_OP, reg_op <= data_in[2:0] and reg_res/flags load the ALU output of reg_A, reg_B and data_in[2:0] in the same edge.
REQ-014 Result and flags SHALL be visible on outputs the cycle after the WAIT_OP enter pulse (latency 1).
REQ-015 Opcodes: 0 ADD, 1 SUB (A-B), 2 AND, 3 OR, 4 XOR, 5 SHL A by 1, 6 SHR A by 1 (logical), 7 pass A.
REQ-016 Result SHALL be WIDTH bits and wrap modulo 2^WIDTH; C = carry-out (ADD), not-borrow (SUB), shifted-out bit (SHL/SHR), 0 otherwise.
REQ-017 V = two's-complement overflow for ADD/SUB, 0 otherwise; N = result MSB; Z = result == 0.
REQ-018 Display value SHALL be data_in in WAIT_A/WAIT_B/WAIT_OP and reg_res in SHOW_RES.
REQ-019 Scan counter counts 0..REFRESH_CNT-1, then wraps and advances digit index 0..7 cyclically.
REQ-020 Digit i SHALL show hex nibble [4i+3:4i] when i < WIDTH/4; digits i >= WIDTH/4 SHALL be blank (anodes bit high).
REQ-021 enter in SHOW_RES SHALL return to WAIT_A without clearing reg_res or flags.
REQ-022 enter held high for N cycles SHALL advance N states (no edge detection inside block).

Reset
REQ-023 reset low SHALL asynchronously set state WAIT_A, reg_A/reg_B/reg_res/flags 0, reg_op 0, scan counter and digit index 0.
REQ-024 During and after reset, anodes SHALL be 8'hFE with segments showing data_in[3:0]; reset mid-sequence SHALL discard partially entered operands.

Configuration
REQ-025 Macro ALU_SEQ_FLAGS_EN defined: flags register built per REQ-017 and driven on flags.
REQ-026 Macro absent: no flag logic; flags SHALL be constant 4'b0000; all other behaviour unchanged.

Structure
REQ-027 Package alu_seq_pkg SHALL hold the opcode enum, FSM state enum, and the 16-entry hex-to-segment constant table.
REQ-028 Digit scanning and nibble decode SHALL be sub-module seg7_scan (parameters WIDTH, REFRESH_CNT); FSM and ALU stay in alu_seq_display.

Verification
REQ-029 WIDTH=8: A=8'h7F, B=8'h01, op 0 -> result 8'h80, flags N=1,Z=0,C=0,V=1 one cycle after third enter.
REQ-030 WIDTH=8: A=8'h05, B=8'h05, op 1 -> result 8'h00, Z=1, C=1, V=0; op 5 with A=8'h81 -> 8'h02, C=1.
REQ-031 WIDTH=8, REFRESH_CNT=4: anodes step FE,FD,FB,...,7F every 4 cycles; digits 2..7 blank; SHOW_RES of 8'hA3 shows 3 then A.
REQ-032 reset low asserted in WAIT_OP -> state_o 0, flags 0, anodes FE immediately, before next clk edge.
REQ-033 enter held 5 cycles from WAIT_A -> state_o sequence 1,2,3,0,1.
REQ-034 Build without ALU_SEQ_FLAGS_EN, repeat REQ-029 -> result 8'h80, flags 4'b0000.
